// File: rtl/usb_rx_ram_ctrl.sv
// ============================================================================
//  Module   : usb_rx_ram_ctrl
//  Brief    : Packs USB RX bytes into 32-bit words and writes them into a
//             host-drained ring buffer RAM, tracking fill level and packets.
//  Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module usb_rx_ram_ctrl #(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              clr,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    input  logic              rx_eop,
    output logic              rx_ready,
    output logic [ADDR_W-1:0] ram_address,
    output logic [3:0]        ram_byteenable,
    output logic              ram_chipselect,
    output logic              ram_write,
    output logic [31:0]       ram_writedata,
    input  logic [9:0]        rd_ptr_wdata,
    input  logic              rd_ptr_we,
    output logic [9:0]        wr_ptr,
    output logic [10:0]       level,
    output logic              pkt_done,
    output logic [15:0]       pkt_len,
    output logic              ptr_err
);

    localparam logic [11:0] c_DEPTH12 = 12'(DEPTH);
    localparam logic [10:0] c_DEPTH11 = 11'(DEPTH);
    localparam logic [9:0]  c_LAST    = 10'(DEPTH - 1);

    logic [9:0]  wr_ptr_q, wr_ptr_d;
    logic [9:0]  rd_ptr_q, rd_ptr_d;
    logic [10:0] level_q,  level_d;
    logic [1:0]  idx_q,    idx_d;
    logic [31:0] word_q,   word_d;
    logic        wr_q,     wr_d;
    logic [3:0]  be_q,     be_d;
    logic [31:0] data_q,   data_d;
    logic        done_q,   done_d;
    logic [15:0] len_q,    len_d;
    logic [15:0] cnt_q,    cnt_d;
    logic        err_q,    err_d;

    logic        w_write;
    logic [11:0] w_committed;
    logic        w_accept;
    logic        w_last;
    logic [31:0] w_word;
    logic [3:0]  w_be;
    logic [15:0] w_cnt_inc;
    logic [10:0] w_freed;
    logic        w_rd_ok;

    // A write already on the bus is still cancelled by a coincident soft clear.
    assign w_write     = wr_q & ~clr;
    assign w_committed = {1'b0, level_q} + {11'b0, wr_q};
    assign rx_ready    = reset_n & enable & ~clr & (w_committed < c_DEPTH12);
    assign w_accept    = rx_valid & rx_ready;
    assign w_last      = (idx_q == 2'd3) | rx_eop;
    assign w_cnt_inc   = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

    always_comb begin
        w_word = word_q;
        w_word[{idx_q, 3'b000} +: 8] = rx_data;
    end

    always_comb begin
        case (idx_q)
            2'd0:    w_be = 4'b0001;
            2'd1:    w_be = 4'b0011;
            2'd2:    w_be = 4'b0111;
            default: w_be = 4'b1111;
        endcase
    end

    always_comb begin
        if (rd_ptr_wdata >= rd_ptr_q)
            w_freed = {1'b0, rd_ptr_wdata} - {1'b0, rd_ptr_q};
        else
            w_freed = {1'b0, rd_ptr_wdata} + c_DEPTH11 - {1'b0, rd_ptr_q};
    end

    assign w_rd_ok = rd_ptr_we & (w_freed <= level_q);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        idx_d    = idx_q;
        word_d   = word_q;
        wr_d     = 1'b0;
        be_d     = be_q;
        data_d   = data_q;
        done_d   = 1'b0;
        len_d    = len_q;
        cnt_d    = cnt_q;
        err_d    = err_q;

        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            idx_d    = '0;
            word_d   = '0;
            len_d    = '0;
            cnt_d    = '0;
            err_d    = 1'b0;
        end else begin
            if (w_write)
                wr_ptr_d = (wr_ptr_q == c_LAST) ? 10'd0 : wr_ptr_q + 10'd1;

            // freed never exceeds level when legal, so this cannot underflow.
            level_d = level_q + {10'b0, w_write} - (w_rd_ok ? w_freed : 11'd0);

            if (rd_ptr_we) begin
                if (w_rd_ok)
                    rd_ptr_d = rd_ptr_wdata;
                else
                    err_d = 1'b1;
            end

            if (w_accept) begin
                if (w_last) begin
                    wr_d   = 1'b1;
                    data_d = w_word;
                    be_d   = w_be;
                    word_d = '0;
                    idx_d  = '0;
                    if (rx_eop) begin
                        done_d = 1'b1;
                        len_d  = w_cnt_inc;
                        cnt_d  = '0;
                    end else begin
                        cnt_d  = w_cnt_inc;
                    end
                end else begin
                    word_d = w_word;
                    idx_d  = idx_q + 2'd1;
                    cnt_d  = w_cnt_inc;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            idx_q    <= '0;
            word_q   <= '0;
            wr_q     <= 1'b0;
            be_q     <= '0;
            data_q   <= '0;
            done_q   <= 1'b0;
            len_q    <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            idx_q    <= idx_d;
            word_q   <= word_d;
            wr_q     <= wr_d;
            be_q     <= be_d;
            data_q   <= data_d;
            done_q   <= done_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
        end
    end

    assign ram_address    = ADDR_W'(wr_ptr_q);
    assign ram_byteenable = be_q;
    assign ram_chipselect = w_write;
    assign ram_write      = w_write;
    assign ram_writedata  = data_q;
    assign wr_ptr         = wr_ptr_q;
    assign level          = level_q;
    assign pkt_done       = done_q & ~clr;
    assign pkt_len        = len_q;
    assign ptr_err        = err_q;

endmodule

`default_nettype wire

// File: tb/tb_usb_rx_ram_ctrl.sv
// ============================================================================
//  Module   : tb_usb_rx_ram_ctrl
//  Brief    : Scoreboard bench for usb_rx_ram_ctrl with a byte-level model.
//  Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_usb_rx_ram_ctrl;

    logic        clk = 1'b0;
    logic        reset_n, enable, clr;
    logic [7:0]  rx_data;
    logic        rx_valid, rx_eop, rx_ready;
    logic [10:0] ram_address;
    logic [3:0]  ram_byteenable;
    logic        ram_chipselect, ram_write;
    logic [31:0] ram_writedata;
    logic [9:0]  rd_ptr_wdata;
    logic        rd_ptr_we;
    logic [9:0]  wr_ptr;
    logic [10:0] level;
    logic        pkt_done;
    logic [15:0] pkt_len;
    logic        ptr_err;

    always #5 clk = ~clk;

    usb_rx_ram_ctrl #(.DEPTH(1024), .ADDR_W(11)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .clr(clr),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_eop(rx_eop), .rx_ready(rx_ready),
        .ram_address(ram_address), .ram_byteenable(ram_byteenable),
        .ram_chipselect(ram_chipselect), .ram_write(ram_write),
        .ram_writedata(ram_writedata), .rd_ptr_wdata(rd_ptr_wdata),
        .rd_ptr_we(rd_ptr_we), .wr_ptr(wr_ptr), .level(level),
        .pkt_done(pkt_done), .pkt_len(pkt_len), .ptr_err(ptr_err)
    );

    typedef struct {
        int          addr;
        logic [31:0] data;
        logic [3:0]  be;
    } wr_t;

    wr_t exp_q[$];
    int  len_q[$];
    int  checks   = 0;
    int  failures = 0;

    // Reference model: bytes of the word being assembled plus ring bookkeeping.
    logic [7:0] m_word[$];
    int         m_wr, m_level, m_rd, m_cnt;
    logic       m_err;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_word.delete();
        m_wr = 0; m_level = 0; m_rd = 0; m_cnt = 0; m_err = 1'b0;
    endtask

    task automatic model_accept(input logic [7:0] d, input logic eop);
        wr_t w;
        m_word.push_back(d);
        m_cnt = (m_cnt == 65535) ? 65535 : m_cnt + 1;
        if (m_word.size() == 4 || eop) begin
            w.addr = m_wr;
            w.data = '0;
            for (int i = 0; i < m_word.size(); i++)
                w.data = w.data | (32'(m_word[i]) << (8 * i));
            w.be = 4'((1 << m_word.size()) - 1);
            exp_q.push_back(w);
            m_wr = (m_wr + 1) % 1024;
            m_level++;
            m_word.delete();
            if (eop) begin
                len_q.push_back(m_cnt);
                m_cnt = 0;
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic eop);
        bit acc = 1'b0;
        rx_data = d; rx_eop = eop; rx_valid = 1'b1;
        for (int c = 0; c < 64 && !acc; c++) begin
            @(negedge clk);
            acc = rx_ready;
            @(posedge clk);
            #1;
        end
        rx_valid = 1'b0; rx_eop = 1'b0;
        if (acc) model_accept(d, eop);
        else begin
            checks++; failures++;
            $display("FAIL send_timeout actual=stalled required=accepted");
        end
    endtask

    task automatic do_rd(input int newptr);
        int freed;
        freed = ((newptr - m_rd) % 1024 + 1024) % 1024;
        if (freed <= m_level) begin
            m_level = m_level - freed;
            m_rd    = newptr;
        end else begin
            m_err = 1'b1;
        end
        rd_ptr_wdata = 10'(newptr);
        rd_ptr_we    = 1'b1;
        @(posedge clk);
        #1;
        rd_ptr_we = 1'b0;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        model_reset();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rx_ready"}, rx_ready, 0);
        chk({tag, "_ram_write"}, ram_write, 0);
        chk({tag, "_ram_cs"}, ram_chipselect, 0);
        chk({tag, "_ram_be"}, ram_byteenable, 0);
        chk({tag, "_ram_data"}, ram_writedata, 0);
        chk({tag, "_ram_addr"}, ram_address, 0);
        chk({tag, "_wr_ptr"}, wr_ptr, 0);
        chk({tag, "_level"}, level, 0);
        chk({tag, "_pkt_done"}, pkt_done, 0);
        chk({tag, "_pkt_len"}, pkt_len, 0);
        chk({tag, "_ptr_err"}, ptr_err, 0);
    endtask

    // Monitor: every RAM write / packet pulse must match the oldest expectation.
    wr_t mon_w;
    int  mon_len;
    always @(negedge clk) begin
        if (reset_n) begin
            if (ram_write) begin
                if (exp_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_write addr=%0d data=0x%08h required=no_write",
                             ram_address, ram_writedata);
                end else begin
                    mon_w = exp_q.pop_front();
                    chk("wr_addr", ram_address, mon_w.addr);
                    chk("wr_data", ram_writedata, mon_w.data);
                    chk("wr_be", ram_byteenable, mon_w.be);
                    chk("wr_cs", ram_chipselect, 1);
                end
            end
            if (pkt_done) begin
                if (len_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_pkt_done len=%0d required=no_pulse", pkt_len);
                end else begin
                    mon_len = len_q.pop_front();
                    chk("pkt_len", pkt_len, mon_len);
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit acc;
        reset_n = 1'b0; enable = 1'b1; clr = 1'b0;
        rx_data = '0; rx_valid = 1'b0; rx_eop = 1'b0;
        rd_ptr_we = 1'b0; rd_ptr_wdata = '0;
        model_reset();

        #12;
        chk_all_zero("reset");
        @(posedge clk);
        #1 reset_n = 1'b1;
        #1 chk("rdy_after_rst", rx_ready, 1);

        // Eight plain bytes -> two full words.
        for (int i = 1; i <= 8; i++) send_byte(8'(i), 1'b0);
        idle(3);
        chk("level_8b", level, 2);
        chk("wr_ptr_8b", wr_ptr, 2);

        // Five-byte packet ending with a partial word.
        do_clr();
        send_byte(8'h11, 1'b0); send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b0); send_byte(8'h44, 1'b0);
        send_byte(8'hAA, 1'b1);
        idle(3);
        chk("level_pkt5", level, 2);

        // Randomised traffic with enable gaps and host pointer updates.
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                enable = 1'b0;
                idle($urandom_range(1, 3));
                enable = 1'b1;
            end
            if ($urandom_range(0, 9) == 0) begin
                idle(3);
                do_rd((m_rd + int'($urandom_range(0, m_level + 2))) % 1024);
                chk("rnd_level", level, m_level);
                chk("rnd_ptr_err", ptr_err, m_err);
            end
            send_byte(8'($urandom), $urandom_range(0, 5) == 0);
        end
        idle(3);
        chk("rnd_final_level", level, m_level);
        chk("rnd_final_wr_ptr", wr_ptr, m_wr);

        // Illegal pointer update, then clear.
        do_clr();
        for (int i = 0; i < 12; i++) send_byte(8'($urandom), 1'b0);
        idle(3);
        do_rd((m_rd + 5) % 1024);
        chk("bad_rd_level", level, 3);
        chk("bad_rd_err", ptr_err, 1);
        do_clr();
        chk("clr_err", ptr_err, 0);
        chk("clr_level", level, 0);

        // Write and legal read in the same cycle at level 4.
        for (int i = 0; i < 16; i++) send_byte(8'($urandom), 1'b0);
        idle(3);
        chk("level4", level, 4);
        for (int i = 0; i < 4; i++) send_byte(8'($urandom), 1'b0);
        do_rd((m_rd + 2) % 1024);
        idle(3);
        chk("same_cycle_level", level, 3);

        // Fill the ring completely, check back-pressure, then free 16 words.
        do_clr();
        for (int i = 0; i < 4096; i++) send_byte(8'($urandom), 1'b0);
        idle(3);
        chk("full_level", level, 1024);
        chk("full_wr_ptr", wr_ptr, 0);
        chk("full_ready", rx_ready, 0);
        rx_data = 8'h5A; rx_valid = 1'b1; acc = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (rx_ready) acc = 1'b1;
        end
        @(posedge clk);
        #1 rx_valid = 1'b0;
        chk("full_stall", acc, 0);
        do_rd(16);
        chk("freed_level", level, 1008);
        chk("freed_ready", rx_ready, 1);

        // Asynchronous reset mid-word.
        send_byte(8'hC1, 1'b0); send_byte(8'hC2, 1'b0);
        #3 reset_n = 1'b0;
        #1 chk_all_zero("async_rst");
        model_reset();
        @(posedge clk);
        #1 reset_n = 1'b1;
        send_byte(8'hD0, 1'b0); send_byte(8'hD1, 1'b0);
        send_byte(8'hD2, 1'b0); send_byte(8'hD3, 1'b0);
        idle(3);
        chk("post_rst_level", level, 1);
        chk("post_rst_wr_ptr", wr_ptr, 1);

        chk("exp_writes_left", exp_q.size(), 0);
        chk("exp_pkts_left", len_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
